// File: rtl/spi_master_byte.sv
// Byte-level SPI mode-0 master: generates sck/cs_n/mosi and captures miso into rx_data.
// cs_n can stay low across bytes (WAIT) so the host can build multi-byte transactions.
module spi_master_byte #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       last,
    input  logic       end_xfer,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       cs_n
);

    localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SetupLast = 16'(CS_SETUP - 1);
    localparam logic [15:0] HoldLast  = 16'(CS_HOLD - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StWait, StHold, StDesel} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  fall_q, fall_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        last_q, last_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fall_d     = fall_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        last_d     = last_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StSetup;
                    cnt_d      = '0;
                    fall_d     = '0;
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[7];
                    last_d     = last;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StShift: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_shift_d = {rx_shift_q[6:0], miso};
                    end else if (fall_q == 3'd7) begin
                        // Final fall: publish the byte and leave mosi on the last bit.
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = last_q ? StHold : StWait;
                    end else begin
                        mosi_d     = tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        fall_d     = fall_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWait: begin
                // start has priority over end_xfer
                if (start) begin
                    state_d    = StShift;
                    cnt_d      = '0;
                    fall_d     = '0;
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[7];
                    last_d     = last;
                end else if (end_xfer) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StDesel;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDesel: begin
                if (cnt_q == HoldLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != StShift) begin
            sck_d = 1'b0;
        end
        cs_n_d = (state_d == StIdle) || (state_d == StDesel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            fall_q     <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign busy     = (state_q != StIdle) && (state_q != StWait);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte with CLK_DIV=2, CS_SETUP=4, CS_HOLD=4.
// Window w is the interval just after the w-th clock edge following an accepted start.
module tb_spi_master_byte;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic       last;
    logic       end_xfer;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    int total = 0;
    int bad   = 0;

    spi_master_byte #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .last    (last),
        .end_xfer(end_xfer),
        .busy    (busy),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
        total++; if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", sck); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    endtask

    // Starts at window 0 of HOLD; walks HOLD and DESEL into IDLE.
    task automatic check_close(input string tag);
        for (int i = 0; i <= 2 * CS_HOLD; i++) begin
            total++;
            if (sck !== 1'b0) begin bad++; $display("FAIL %s_sck i=%0d got=%b want=0", tag, i, sck); end
            total++;
            if (cs_n !== ((i < CS_HOLD) ? 1'b0 : 1'b1)) begin
                bad++; $display("FAIL %s_cs_n i=%0d got=%b want=%b", tag, i, cs_n, (i >= CS_HOLD));
            end
            total++;
            if (busy !== ((i < 2 * CS_HOLD) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL %s_busy i=%0d got=%b want=%b", tag, i, busy, (i < 2 * CS_HOLD));
            end
            if (i > 0) begin
                total++;
                if (rx_valid !== 1'b0) begin bad++; $display("FAIL %s_rx_valid i=%0d got=1 want=0", tag, i); end
            end
            if (i < 2 * CS_HOLD) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // One byte; returns in the rx_valid window (or after a reset abort).
    task automatic byte_xfer(input logic [7:0] tx, input logic lst, input logic [7:0] sl,
                             input bit from_idle, input bit inj, input bit with_end,
                             input int abort_w, input string tag);
        int s;
        int k;
        int n;
        s = from_idle ? CS_SETUP : 0;
        tx_data  = tx;
        last     = lst;
        start    = 1'b1;
        end_xfer = with_end;
        miso     = sl[7];
        @(posedge clk); #1;
        start    = 1'b0;
        end_xfer = 1'b0;
        for (int w = 0; w <= s + 16 * CLK_DIV; w++) begin
            if (w == abort_w) begin
                rst_n = 1'b0;
                #1;
                total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL %s_abort_cs_n got=%b want=1", tag, cs_n); end
                total++; if (sck !== 1'b0) begin bad++; $display("FAIL %s_abort_sck got=%b want=0", tag, sck); end
                total++; if (mosi !== 1'b0) begin bad++; $display("FAIL %s_abort_mosi got=%b want=0", tag, mosi); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_abort_busy got=%b want=0", tag, busy); end
                total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL %s_abort_rx_data got=%h want=00", tag, rx_data); end
                for (int j = 0; j < 4 * CLK_DIV; j++) begin
                    @(posedge clk); #1;
                    total++;
                    if (rx_valid !== 1'b0) begin bad++; $display("FAIL %s_abort_rx_valid j=%0d got=1 want=0", tag, j); end
                end
                rst_n = 1'b1;
                return;
            end
            total++;
            if (cs_n !== 1'b0) begin bad++; $display("FAIL %s_cs_low w=%0d got=%b want=0", tag, w, cs_n); end
            if (w >= s && ((w - s) % (2 * CLK_DIV)) == CLK_DIV) begin
                k = (w - s) / (2 * CLK_DIV);
                total++;
                if (sck !== 1'b1) begin bad++; $display("FAIL %s_rise k=%0d sck got=%b want=1", tag, k, sck); end
                total++;
                if (mosi !== tx[7-k]) begin
                    bad++; $display("FAIL %s_mosi k=%0d got=%b want=%b", tag, k, mosi, tx[7-k]);
                end
            end
            if (w == s + 16 * CLK_DIV) begin
                total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL %s_rx_valid got=%b want=1", tag, rx_valid); end
                total++; if (rx_data !== sl) begin bad++; $display("FAIL %s_rx_data got=%h want=%h", tag, rx_data, sl); end
                total++; if (busy !== lst) begin bad++; $display("FAIL %s_busy_end got=%b want=%b", tag, busy, lst); end
                total++; if (sck !== 1'b0) begin bad++; $display("FAIL %s_sck_end got=%b want=0", tag, sck); end
                break;
            end
            total++;
            if (rx_valid !== 1'b0) begin bad++; $display("FAIL %s_early_rx_valid w=%0d got=1 want=0", tag, w); end
            n = (w >= s) ? (w - s) / (2 * CLK_DIV) : 0;
            if (n < 8) miso = sl[7-n];
            if (inj && w == s + 5) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_single();
        byte_xfer(8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, -1, "single");
        check_close("single_close");
    endtask

    task automatic test_read_seq();
        byte_xfer(8'h03, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, -1, "read_cmd");
        byte_xfer(8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1, "read_addr");
        byte_xfer(8'h00, 1'b1, 8'hC7, 1'b0, 1'b0, 1'b0, -1, "read_data");
        check_close("read_close");
    endtask

    task automatic test_ignore_start();
        byte_xfer(8'h96, 1'b1, 8'h69, 1'b1, 1'b1, 1'b0, -1, "ignore");
        check_close("ignore_close");
    endtask

    task automatic test_end_xfer();
        byte_xfer(8'h55, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, -1, "endx");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (cs_n !== 1'b0 || sck !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL wait_idle i=%0d cs_n=%b sck=%b busy=%b want 0/0/0", i, cs_n, sck, busy);
            end
        end
        end_xfer = 1'b1;
        @(posedge clk); #1;
        end_xfer = 1'b0;
        check_close("endx_close");
    endtask

    task automatic test_start_and_end();
        byte_xfer(8'h33, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, -1, "both_first");
        byte_xfer(8'h81, 1'b1, 8'hE7, 1'b0, 1'b0, 1'b1, -1, "both");
        check_close("both_close");
    endtask

    task automatic test_reset_mid();
        byte_xfer(8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, CS_SETUP + 5 * CLK_DIV, "rstmid");
        @(posedge clk); #1;
        byte_xfer(8'h5A, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, -1, "after_rst");
        check_close("after_rst_close");
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        tx_data  = 8'h00;
        last     = 1'b0;
        end_xfer = 1'b0;
        miso     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_single();
        test_read_seq();
        test_ignore_start();
        test_end_xfer();
        test_start_and_end();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_byte.md
# spi_master_byte

Byte-level SPI master for the M25AA010A EEPROM link, SPI mode 0 (SCK idle low). It generates SCK, CS_n and MOSI, and captures MISO into a received byte. This is the transmit side of the link: the EEPROM-side logic recovers SCK edges by synchronous edge detection. Multi-byte transactions (command, address, data) keep CS_n low between bytes, under control of the host FSM.

## Interface
- CLK_DIV, 4: clk cycles per SCK half-period; legal range ≥2.
- CS_SETUP, 4: clk cycles from CS_n falling to SCK start (SETUP state length); ≥1.
- CS_HOLD, 4: clk cycles of CS_n low after the last SCK fall, and also minimum CS_n high time before IDLE; ≥1.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start one byte; accepted only in IDLE or WAIT.
- tx_data  in  8  byte to send, MSB first; sampled with an accepted start.
- last  in  1  sampled with start; 1 releases CS_n after this byte.
- end_xfer  in  1  in WAIT, close the transaction without sending a byte.
- busy  out  1  high whenever the FSM is not in IDLE or WAIT.
- rx_data  out  8  last received byte; holds its value until the next byte completes.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- sck  out  1  SPI clock, registered.
- mosi  out  1  SPI data out, registered.
- miso  in  1  SPI data in.
- cs_n  out  1  chip select, active low, registered.

## Operation
- Reset values: cs_n=1, sck=0, mosi=0, busy=0, rx_valid=0, rx_data=8'h00, state=IDLE.
- States:
  - IDLE → SETUP on start.
  - SETUP → SHIFT after CS_SETUP cycles.
  - SHIFT → HOLD when last_q=1, otherwise → WAIT.
  - WAIT → SHIFT on start; WAIT → HOLD on end_xfer.
  - HOLD → DESEL after CS_HOLD cycles.
  - DESEL → IDLE after CS_HOLD cycles.
- On an accepted start: latch tx_data into the shift register and last into last_q. Drive mosi=tx_data[7] on the next cycle.
- cs_n is low in SETUP, SHIFT, WAIT and HOLD; high in IDLE and DESEL.
- sck toggles only in SHIFT. It is forced to 0 in every other state.
- SHIFT uses a divider counter running 0..CLK_DIV-1. sck toggles when the counter reaches terminal count, giving 16 toggles per byte.
- Rising toggle (sck 0→1): on that same clk edge, miso shifts into the LSB of rx_shift.
- Falling toggle (sck 1→0), toggles 1–7: mosi advances to the next bit. The 8th falling toggle leaves mosi unchanged.
- 8th falling toggle: rx_data ← rx_shift (including the bit captured on the 8th rise), rx_valid pulses, and the FSM leaves SHIFT.
- start while busy=1 is ignored; there is no queueing.
- end_xfer outside WAIT is ignored. If start and end_xfer are both high in WAIT, start wins.
- In WAIT, cs_n stays low indefinitely until start or end_xfer arrives.
- Asserting rst_n low mid-transfer forces the reset values immediately. The partial byte is discarded and rx_valid does not pulse.

## Timing
- Start accepted at cycle T (IDLE): cs_n=0, busy=1 and mosi=tx_data[7] at T+1. SHIFT begins at S=T+1+CS_SETUP.
- Start accepted at cycle T (WAIT): SHIFT begins at S=T+1 with mosi=tx_data[7]. There is no setup delay.
- SCK edges (bit k=0..7):
  - rising at S+CLK_DIV·(2k+1);
  - falling at S+CLK_DIV·(2k+2).
- rx_valid is high for exactly the one cycle in which sck first reads 0 after the 8th fall, cycle S+16·CLK_DIV. Byte latency is 16·CLK_DIV clk cycles.
- After the final byte:
  - HOLD occupies S+16·CLK_DIV … +CS_HOLD−1;
  - cs_n rises at S+16·CLK_DIV+CS_HOLD;
  - busy falls CS_HOLD cycles after that.
- For a non-last byte, busy falls in the rx_valid cycle. The earliest next start is the same cycle.
- mosi is stable for one SCK half-period before and after each rising edge.

## Test plan
- CLK_DIV=2, CS_SETUP=4, CS_HOLD=4: single byte 0xA5 with last=1, slave drives 0x3C.
  - Expect mosi bits 1,0,1,0,0,1,0,1 at the rising edges.
  - Expect rx_data=0x3C with one rx_valid at S+32.
  - Expect cs_n high 4 cycles after the last fall, then busy low 4 cycles later.
- READ sequence 0x03 (last=0), 0x12 (last=0), 0x00 (last=1), slave returns 0xC7 on the third byte.
  - cs_n must stay low across all three bytes.
  - Expect three rx_valid pulses; the final rx_data=0xC7.
- start pulsed mid-SHIFT with tx_data=0xFF: ignored. The byte in progress and mosi are unchanged, and no extra rx_valid occurs.
- 0x55 with last=0, then end_xfer in WAIT: HOLD then DESEL follow, cs_n=1 after CS_HOLD cycles, and sck never toggles.
- start and end_xfer both high in WAIT with 0x81: a byte is sent and end_xfer is ignored.
- rst_n low after the 3rd SCK rise: cs_n=1, sck=0, mosi=0 and busy=0 immediately. No rx_valid pulses. A subsequent byte (0x5A, slave 0x0F) gives rx_data=0x0F.
